// File: rtl/apb_pkg.sv
// Shared definitions for the APB4 memory slave: FSM states, error codes, strobe width.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } apb_state_e;

  localparam logic PSLVERR_OK  = 1'b0;
  localparam logic PSLVERR_ERR = 1'b1;

  function automatic int unsigned strb_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/apb_strb_ram.sv
// DEPTH x DW word array with per-byte write enables, synchronous clear and registered read port.
module apb_strb_ram #(
  parameter int unsigned DEPTH = 12,
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic            re,
  input  logic            rclr,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] strb,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem [DEPTH];

  // rdata only moves on a read strobe so it holds between transfers; rclr forces zero for errors
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) begin
        for (int unsigned b = 0; b < DW / 8; b++) begin
          if (strb[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
      if (re) rdata <= rclr ? '0 : mem[addr];
    end
  end

endmodule

// File: rtl/apb4_mem_slave.sv
// Parametrised APB4 memory slave: wait-state FSM, range check and registered response.
module apb4_mem_slave
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 12,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                                pclk,
  input  logic                                prst,
  input  logic                                psel,
  input  logic                                penable,
  input  logic                                pwrite,
  input  logic [ADDR_WIDTH-1:0]               paddr,
  input  logic [DATA_WIDTH-1:0]               pwdata,
  input  logic [strb_width(DATA_WIDTH)-1:0]   pstrb,
  output logic [DATA_WIDTH-1:0]               prdata,
  output logic                                pready,
  output logic                                pslverr
);

  apb_state_e state_q, state_d;
  logic [3:0] cnt_q;
  logic       load, dec, access;
  logic       in_range;

  assign in_range = (32'(paddr) < MEM_DEPTH);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    dec     = 1'b0;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && penable) begin
          state_d = WAIT;
          load    = 1'b1;
        end
      end
      WAIT: begin
        if (!(psel && penable)) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          access  = 1'b1;
          state_d = DONE;
        end else begin
          dec = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pready  <= 1'b0;
      pslverr <= PSLVERR_OK;
    end else begin
      state_q <= state_d;
      if (load)     cnt_q <= 4'(WAIT_STATES);
      else if (dec) cnt_q <= cnt_q - 4'd1;
      pready  <= access;
      pslverr <= (access && !in_range) ? PSLVERR_ERR : PSLVERR_OK;
    end
  end

  // Out-of-range accesses of either direction take the read path with clear, so prdata shows 0
  apb_strb_ram #(
    .DEPTH(MEM_DEPTH),
    .DW   (DATA_WIDTH),
    .AW   (ADDR_WIDTH)
  ) u_ram (
    .clk  (pclk),
    .rst  (prst),
    .we   (access && pwrite && in_range),
    .re   (access && (!pwrite || !in_range)),
    .rclr (!in_range),
    .addr (paddr),
    .wdata(pwdata),
    .strb (pstrb),
    .rdata(prdata)
  );

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Directed bench for apb4_mem_slave: three instances (0/3/4 wait states) checked every cycle against a word-array model.
module tb_apb4_mem_slave;

  localparam int WS_T [3] = '{0, 3, 4};
  localparam int DEPTH = 12;

  logic        clk = 1'b0;
  logic        prst;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata_w [3];
  logic [2:0]  pready_w;
  logic [2:0]  pslverr_w;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  logic [31:0] model [3][16];
  logic [31:0] held [3];
  int          exp_cyc [3];
  logic        exp_err [3];
  logic        exp_upd [3];
  logic [31:0] exp_data [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb4_mem_slave #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .pclk(clk), .prst(prst), .psel(psel[0]), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_w[0]), .pready(pready_w[0]), .pslverr(pslverr_w[0]));
  apb4_mem_slave #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
    .pclk(clk), .prst(prst), .psel(psel[1]), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_w[1]), .pready(pready_w[1]), .pslverr(pslverr_w[1]));
  apb4_mem_slave #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(4)) u_ws4 (
    .pclk(clk), .prst(prst), .psel(psel[2]), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_w[2]), .pready(pready_w[2]), .pslverr(pslverr_w[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < 16; a++) model[k][a] = '0;
      held[k]    = '0;
      exp_cyc[k] = -1;
    end
  endtask

  task automatic apply_reset(input int n);
    prst = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick(1);
      for (int k = 0; k < 3; k++) chk("reset_pready", 32'(pready_w[k]), 32'd0);
    end
    model_clear();
    prst = 1'b0;
  endtask

  // Full transfer: pready expected in cycle start+WS+2; returns at the cycle after DONE.
  task automatic xfer(input int k, input logic w, input logic [3:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    psel    = '0;
    psel[k] = 1'b1;
    penable = 1'b1;
    pwrite  = w;
    paddr   = a;
    pwdata  = d;
    pstrb   = s;
    exp_cyc[k] = cyc + WS_T[k] + 2;
    if (int'(a) >= DEPTH) begin
      exp_err[k]  = 1'b1;
      exp_upd[k]  = 1'b1;
      exp_data[k] = '0;
    end else begin
      exp_err[k]  = 1'b0;
      exp_upd[k]  = !w;
      exp_data[k] = model[k][a];
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) model[k][a][8*b +: 8] = d[8*b +: 8];
      end
    end
    tick(WS_T[k] + 3);
    psel    = '0;
    penable = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        for (int k = 0; k < 3; k++) begin
          if (cyc == exp_cyc[k]) begin
            if (exp_upd[k]) held[k] = exp_data[k];
            chk("pready_done", 32'(pready_w[k]), 32'd1);
            chk("pslverr_done", 32'(pslverr_w[k]), 32'(exp_err[k]));
          end else begin
            chk("pready_idle", 32'(pready_w[k]), 32'd0);
            chk("pslverr_idle", 32'(pslverr_w[k]), 32'd0);
          end
          chk("prdata", prdata_w[k], held[k]);
        end
      end
    end
  end

  logic [3:0]  b2b_idx [8] = '{4'd0, 4'd7, 4'd11, 4'd4, 4'd9, 4'd1, 4'd6, 4'd10};
  logic [31:0] b2b_dat [8] = '{32'h0123_4567, 32'h89AB_CDEF, 32'hFFFF_FFFF, 32'h5A5A_A5A5,
                               32'h0000_0001, 32'h8000_0000, 32'hC3C3_3C3C, 32'h7777_1111};

  initial begin
    prst = 1'b1; psel = '0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    model_clear();
    apply_reset(2);
    checking = 1'b1;

    for (int a = 0; a < DEPTH; a++) xfer(0, 1'b0, 4'(a), '0, '0);

    xfer(0, 1'b1, 4'd3, 32'hDEAD_BEEF, 4'hF);
    xfer(0, 1'b0, 4'd3, '0, '0);
    chk("rd3_literal", prdata_w[0], 32'hDEAD_BEEF);

    xfer(0, 1'b1, 4'd5, 32'h1122_3344, 4'hF);
    xfer(0, 1'b1, 4'd5, 32'hAABB_CCDD, 4'b0101);
    xfer(0, 1'b0, 4'd5, '0, '0);
    chk("strb_literal", prdata_w[0], 32'h11BB_33DD);
    xfer(0, 1'b1, 4'd5, 32'hFFFF_FFFF, 4'h0);
    xfer(0, 1'b0, 4'd5, '0, '0);
    chk("strb0_literal", prdata_w[0], 32'h11BB_33DD);
    tick(2);

    xfer(1, 1'b1, 4'd11, 32'h0BAD_0BAD, 4'hF);
    xfer(1, 1'b0, 4'd11, '0, '0);
    chk("ws3_rd11_literal", prdata_w[1], 32'h0BAD_0BAD);
    xfer(1, 1'b1, 4'd12, 32'hFFFF_FFFF, 4'hF);
    chk("err_wr_prdata_literal", prdata_w[1], 32'd0);
    xfer(1, 1'b0, 4'd15, '0, '0);
    chk("err_rd_prdata_literal", prdata_w[1], 32'd0);
    for (int a = 0; a < DEPTH; a++) xfer(1, 1'b0, 4'(a), '0, '0);
    tick(2);

    xfer(2, 1'b1, 4'd2, 32'hCAFE_F00D, 4'hF);
    psel = 3'b100; penable = 1'b1; pwrite = 1'b1; paddr = 4'd2;
    pwdata = 32'h1234_5678; pstrb = 4'hF;
    tick(3);
    psel = '0; penable = 1'b0;
    tick(8);
    xfer(2, 1'b0, 4'd2, '0, '0);
    chk("abort_literal", prdata_w[2], 32'hCAFE_F00D);

    psel = 3'b100; penable = 1'b1; pwrite = 1'b1; paddr = 4'd8;
    pwdata = 32'hA5A5_A5A5; pstrb = 4'hF;
    tick(WS_T[2] + 1);
    prst = 1'b1;
    tick(1);
    model_clear();
    prst = 1'b0; psel = '0; penable = 1'b0;
    tick(3);
    xfer(2, 1'b0, 4'd8, '0, '0);
    chk("rst_mid_literal", prdata_w[2], 32'd0);
    xfer(2, 1'b0, 4'd2, '0, '0);

    for (int i = 0; i < 8; i++) begin
      xfer(0, 1'b1, b2b_idx[i], b2b_dat[i], 4'hF);
      xfer(0, 1'b0, b2b_idx[i], '0, '0);
    end
    chk("b2b_last_literal", prdata_w[0], 32'h7777_1111);
    tick(3);

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
